dma_req_arbiter: RTL

- Shares the single DMA/AXI transfer engine between the cache's two DMA requesters: page-fault refill (read) and write-back flush (write).
- Accepts level-held happen/done requests, picks one with write-back priority and a starvation guard, and issues one command to the engine over a valid/ready handshake.
- Waits for engine completion, or a timeout, then returns a one-cycle done pulse to the requester that was granted.
- Sits in the cpu_clk domain, between the cache controller and the AXI read/write engines.

---
 rtl/dma_req_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dma_req_arbiter.sv
// Arbitrates the cache's refill and write-back DMA requests onto one engine.
// Write-back wins ties, bounded by a streak guard; completions time out.
module dma_req_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int READ_BURST_LEN  = 8,
  parameter int WRITE_BURST_LEN = 8,
  parameter int TIMEOUT_CYC     = 256,
  parameter int WB_MAX_STREAK   = 4
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rst_n,
  input  logic                       dma_page_fault_happen,
  input  logic [ADDR_WIDTH-1:0]      dma_page_fault_addr,
  input  logic [READ_BURST_LEN-1:0]  dma_page_fault_burst_len,
  output logic                       dma_page_fault_done,
  input  logic                       dma_write_back_happen,
  input  logic [ADDR_WIDTH-1:0]      dma_write_back_addr,
  input  logic [WRITE_BURST_LEN-1:0] dma_write_back_burst_len,
  output logic                       dma_write_back_done,
  output logic                       eng_cmd_valid,
  input  logic                       eng_cmd_ready,
  output logic                       eng_cmd_write,
  output logic [ADDR_WIDTH-1:0]      eng_cmd_addr,
  output logic [WRITE_BURST_LEN-1:0] eng_cmd_len,
  input  logic                       eng_done,
  output logic                       busy,
  output logic                       timeout_err,
  output logic                       timeout_sticky
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int SW = $clog2(WB_MAX_STREAK + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(WB_MAX_STREAK);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e                     state_q, state_d;
  logic                       write_q, write_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [WRITE_BURST_LEN-1:0] len_q, len_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [SW-1:0]              streak_q, streak_d;
  logic                       to_q, to_d;
  logic                       sticky_q, sticky_d;

  logic pf_h, wb_h, in_idle;
  logic grant_wb, grant_pf, cnt_hit;

  assign pf_h    = dma_page_fault_happen;
  assign wb_h    = dma_write_back_happen;
  assign in_idle = (state_q == S_IDLE);
  assign cnt_hit = (cnt_q == CNT_LAST);

  // Page fault only overrides a pending write-back once the streak is full.
  assign grant_wb = in_idle & wb_h
                  & ~(pf_h & (streak_q == STREAK_MAX));
  assign grant_pf = in_idle & pf_h & ~grant_wb;

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (pf_h || wb_h) state_d = S_ISSUE;
      S_ISSUE: if (eng_cmd_ready) state_d = S_WAIT;
      S_WAIT:  if (eng_done || cnt_hit) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    write_d  = write_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    streak_d = streak_q;
    if (grant_wb) begin
      write_d = 1'b1;
      addr_d  = dma_write_back_addr;
      len_d   = dma_write_back_burst_len;
      if (pf_h && streak_q != STREAK_MAX)
        streak_d = streak_q + SW'(1);
    end else if (grant_pf) begin
      write_d  = 1'b0;
      addr_d   = dma_page_fault_addr;
      len_d    = WRITE_BURST_LEN'(dma_page_fault_burst_len);
      streak_d = '0;
    end
    if (state_q == S_ISSUE)     cnt_d = '0;
    else if (state_q == S_WAIT) cnt_d = cnt_q + CW'(1);
    // A completion in the last wait cycle beats the timeout.
    to_d     = (state_q == S_WAIT) & cnt_hit & ~eng_done;
    sticky_d = sticky_q | to_d;
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      write_q  <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      streak_q <= '0;
      to_q     <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      write_q  <= write_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      streak_q <= streak_d;
      to_q     <= to_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    eng_cmd_valid       = (state_q == S_ISSUE);
    eng_cmd_write       = write_q;
    eng_cmd_addr        = addr_q;
    eng_cmd_len         = len_q;
    busy                = ~in_idle;
    dma_write_back_done = (state_q == S_RESP) & write_q;
    dma_page_fault_done = (state_q == S_RESP) & ~write_q;
    timeout_err         = (state_q == S_RESP) & to_q;
    timeout_sticky      = sticky_q;
  end

endmodule
